// File: rtl/streaming_bot_feeder_if.sv
// Upstream graph stream into the bot feeder: valid/ready handshake carrying one graph per beat.
interface streaming_bot_feeder_if;
  logic         graphValid;
  logic [127:0] graphIn;
  logic         graphLast;
  logic         graphReady;

  modport master (output graphValid, graphIn, graphLast, input graphReady);
  modport slave  (input graphValid, graphIn, graphLast, output graphReady);
endinterface

// File: rtl/streaming_bot_feeder.sv
// Input-side producer for streamingCountConnectedCore: issues one tagged bot per clk under
// slowDownInput backpressure and tracks in-flight bots until the job's last result returns.
module streaming_bot_feeder #(
  parameter int unsigned TAG_WIDTH      = 4,
  parameter int unsigned INFLIGHT_WIDTH = 10,
  parameter int unsigned COUNT_WIDTH    = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [TAG_WIDTH-1:0]      startTag,
  streaming_bot_feeder_if.slave     up,
  output logic                      isBotValid,
  output logic [127:0]              graphOut,
  output logic [TAG_WIDTH:0]        extraDataOut,
  input  logic                      slowDownInput,
  input  logic                      resultValid,
  input  logic [TAG_WIDTH:0]        extraDataIn,
  output logic                      busy,
  output logic                      jobDone,
  output logic [COUNT_WIDTH-1:0]    botsIssued,
  output logic [INFLIGHT_WIDTH-1:0] inFlight,
  output logic                      protocolError
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e                    state;
  logic                      slowReg;
  logic                      lastSeen;
  logic [TAG_WIDTH-1:0]      jobTag;

  logic                      transfer;
  logic                      active;
  logic                      resLast;
  logic                      resDec;
  logic                      saturate;
  logic                      resultError;
  logic                      lastSeenNext;
  logic [INFLIGHT_WIDTH-1:0] inFlightNext;

  // Ready depends on registers only; the registered slowDown costs at most two extra bots.
  assign up.graphReady = (state == StRun) && !slowReg;
  assign transfer      = up.graphValid && up.graphReady;

  assign active   = (state == StRun) || (state == StDrain);
  assign resLast  = extraDataIn[TAG_WIDTH];
  assign resDec   = active && resultValid && (inFlight != '0);
  assign saturate = isBotValid && !resDec && (&inFlight);

  // inFlight excludes a bot issued this same cycle, so a legal last result sees exactly one.
  assign resultError = active && resultValid &&
                       ((inFlight == '0) || (extraDataIn[TAG_WIDTH-1:0] != jobTag) ||
                        (resLast && (inFlight != INFLIGHT_WIDTH'(1))));
  assign lastSeenNext = lastSeen || (active && resultValid && resLast);

  always_comb begin
    inFlightNext = inFlight;
    if (isBotValid && !resDec && !saturate) begin
      inFlightNext = inFlight + INFLIGHT_WIDTH'(1);
    end else if (!isBotValid && resDec) begin
      inFlightNext = inFlight - INFLIGHT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= StIdle;
      slowReg       <= 1'b0;
      lastSeen      <= 1'b0;
      jobTag        <= '0;
      isBotValid    <= 1'b0;
      graphOut      <= '0;
      extraDataOut  <= '0;
      busy          <= 1'b0;
      jobDone       <= 1'b0;
      botsIssued    <= '0;
      inFlight      <= '0;
      protocolError <= 1'b0;
    end else begin
      slowReg    <= slowDownInput;
      isBotValid <= transfer;
      inFlight   <= inFlightNext;
      jobDone    <= 1'b0;
      if (transfer) begin
        graphOut     <= up.graphIn;
        extraDataOut <= {up.graphLast, jobTag};
        botsIssued   <= botsIssued + COUNT_WIDTH'(1);
      end
      if (resultError || saturate) begin
        protocolError <= 1'b1;
      end
      unique case (state)
        StIdle: begin
          if (start) begin
            state      <= StRun;
            jobTag     <= startTag;
            botsIssued <= '0;
            lastSeen   <= 1'b0;
            busy       <= 1'b1;
          end
        end
        StRun: begin
          lastSeen <= lastSeenNext;
          if (transfer && up.graphLast) begin
            state <= StDrain;
          end
        end
        StDrain: begin
          lastSeen <= lastSeenNext;
          if (lastSeenNext && (inFlightNext == '0)) begin
            state   <= StDone;
            jobDone <= 1'b1;
          end
        end
        StDone: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_streaming_bot_feeder.sv
// Directed bench for streaming_bot_feeder with a fixed-latency core model on the result side.
module tb_streaming_bot_feeder;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   startTag;
  logic         isBotValid;
  logic [127:0] graphOut;
  logic [4:0]   extraDataOut;
  logic         slowDownInput;
  logic         resultValid;
  logic [4:0]   extraDataIn;
  logic         busy;
  logic         jobDone;
  logic [31:0]  botsIssued;
  logic [9:0]   inFlight;
  logic         protocolError;

  streaming_bot_feeder_if up ();

  streaming_bot_feeder dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .startTag      (startTag),
    .up            (up),
    .isBotValid    (isBotValid),
    .graphOut      (graphOut),
    .extraDataOut  (extraDataOut),
    .slowDownInput (slowDownInput),
    .resultValid   (resultValid),
    .extraDataIn   (extraDataIn),
    .busy          (busy),
    .jobDone       (jobDone),
    .botsIssued    (botsIssued),
    .inFlight      (inFlight),
    .protocolError (protocolError)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nTests = 0;
  int nFail  = 0;

  typedef struct {
    int         due;
    logic [4:0] ed;
  } pend_t;

  pend_t        pend[$];
  logic [4:0]   issTag[$];
  logic [127:0] issGraph[$];
  int           issCyc[$];
  int           latency    = 10;
  bit           inj        = 1'b0;
  logic [4:0]   injData    = '0;
  int           lastResCyc = -1;

  // Core model: returns each bot's tag 'latency' cycles after issue, in order; also logs issues.
  initial begin
    resultValid = 1'b0;
    extraDataIn = '0;
    forever begin
      @(negedge clk);
      if (isBotValid === 1'b1) begin
        pend.push_back('{cyc + latency, extraDataOut});
        issTag.push_back(extraDataOut);
        issGraph.push_back(graphOut);
        issCyc.push_back(cyc);
      end
      if (inj) begin
        resultValid = 1'b1;
        extraDataIn = injData;
      end else if (pend.size() > 0 && pend[0].due <= cyc) begin
        resultValid = 1'b1;
        extraDataIn = pend[0].ed;
        lastResCyc  = cyc;
        void'(pend.pop_front());
      end else begin
        resultValid = 1'b0;
      end
    end
  end

  task automatic clearLogs();
    pend.delete();
    issTag.delete();
    issGraph.delete();
    issCyc.delete();
  endtask

  task automatic startJob(input logic [3:0] tag);
    @(posedge clk); #1;
    start    = 1'b1;
    startTag = tag;
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  task automatic sendJob(input int n, input logic [127:0] base, input int budget, output int sent);
    int i = 0;
    int waited = 0;
    while (i < n && waited < budget) begin
      up.graphValid = 1'b1;
      up.graphIn    = base + 128'(i);
      up.graphLast  = (i == n - 1);
      @(negedge clk);
      if (up.graphReady === 1'b1) i++;
      @(posedge clk); #1;
      waited++;
    end
    up.graphValid = 1'b0;
    up.graphLast  = 1'b0;
    sent = i;
  endtask

  task automatic waitDone(input int budget, output int doneCyc);
    doneCyc = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (jobDone === 1'b1) begin
        doneCyc = cyc;
        break;
      end
    end
  endtask

  task automatic injectResult(input logic [4:0] data);
    @(posedge clk); #1;
    inj     = 1'b1;
    injData = data;
    @(posedge clk); #1;
    inj     = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    nTests++;
    if ({busy, up.graphReady, isBotValid, jobDone, protocolError} !== 5'b0) begin
      nFail++;
      $display("FAIL reset.flags: got %b expected 00000",
               {busy, up.graphReady, isBotValid, jobDone, protocolError});
    end
    nTests++;
    if (botsIssued !== 32'd0 || inFlight !== 10'd0) begin
      nFail++;
      $display("FAIL reset.counters: got bots=%0d inFlight=%0d expected 0/0", botsIssued, inFlight);
    end
    nTests++;
    if (graphOut !== 128'd0 || extraDataOut !== 5'd0) begin
      nFail++;
      $display("FAIL reset.data: got graph=%h extra=%h expected 0/0", graphOut, extraDataOut);
    end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    int sent, doneCyc, bad;
    logic [4:0] expTag;
    clearLogs();
    latency = 512;
    startJob(4'd3);
    nTests++;
    if (busy !== 1'b1 || up.graphReady !== 1'b1) begin
      nFail++;
      $display("FAIL b2b.run_entry: got busy=%b ready=%b expected 1/1", busy, up.graphReady);
    end
    sendJob(5, 128'h100, 50, sent);
    waitDone(700, doneCyc);
    nTests++;
    if (issCyc.size() != 5) begin
      nFail++;
      $display("FAIL b2b.issue_count: got %0d expected 5", issCyc.size());
    end
    bad = 0;
    for (int k = 0; k < issCyc.size(); k++) begin
      expTag = (k == 4) ? 5'h13 : 5'h03;
      if (issCyc[k] != issCyc[0] + k || issTag[k] !== expTag || issGraph[k] !== 128'h100 + k) begin
        bad++;
        $display("FAIL b2b.issue[%0d]: got cyc+%0d tag=%h graph=%h expected cyc+%0d tag=%h graph=%h",
                 k, issCyc[k] - issCyc[0], issTag[k], issGraph[k], k, expTag, 128'h100 + k);
      end
    end
    nTests++;
    if (bad != 0) nFail++;
    nTests++;
    if (doneCyc < 0 || doneCyc != lastResCyc + 1) begin
      nFail++;
      $display("FAIL b2b.jobdone_timing: got cycle %0d expected %0d", doneCyc, lastResCyc + 1);
    end
    nTests++;
    if (botsIssued !== 32'd5 || inFlight !== 10'd0) begin
      nFail++;
      $display("FAIL b2b.counters: got bots=%0d inFlight=%0d expected 5/0", botsIssued, inFlight);
    end
    @(negedge clk);
    nTests++;
    if (jobDone !== 1'b0 || busy !== 1'b0 || botsIssued !== 32'd5) begin
      nFail++;
      $display("FAIL b2b.after_done: got done=%b busy=%b bots=%0d expected 0/0/5",
               jobDone, busy, botsIssued);
    end
  endtask

  task automatic test_slowdown();
    int sent, doneCyc, tSlow, uSlow, readyBad, after, bad;
    logic resumeReady;
    logic [4:0] expTag;
    clearLogs();
    latency  = 64;
    readyBad = 0;
    tSlow    = 0;
    uSlow    = 0;
    startJob(4'd6);
    fork
      sendJob(40, 128'h2000, 400, sent);
      begin
        int w = 0;
        while (issCyc.size() < 10 && w < 200) begin
          @(posedge clk);
          w++;
        end
        #1;
        slowDownInput = 1'b1;
        tSlow = cyc;
        @(negedge clk);
        repeat (8) begin
          @(negedge clk);
          if (up.graphReady !== 1'b0) readyBad++;
        end
        @(posedge clk); #1;
        slowDownInput = 1'b0;
        uSlow = cyc;
        @(negedge clk);
        if (up.graphReady !== 1'b0) readyBad++;
        @(negedge clk);
        resumeReady = up.graphReady;
      end
    join
    waitDone(200, doneCyc);
    nTests++;
    if (readyBad != 0) begin
      nFail++;
      $display("FAIL slow.ready_low: got %0d cycles ready high expected 0", readyBad);
    end
    after = 0;
    foreach (issCyc[k]) if (issCyc[k] > tSlow && issCyc[k] <= uSlow + 1) after++;
    nTests++;
    if (after > 2) begin
      nFail++;
      $display("FAIL slow.extra_issues: got %0d expected <=2", after);
    end
    nTests++;
    if (resumeReady !== 1'b1) begin
      nFail++;
      $display("FAIL slow.resume: got ready=%b expected 1", resumeReady);
    end
    bad = 0;
    for (int k = 0; k < issGraph.size(); k++) begin
      expTag = (k == 39) ? 5'h16 : 5'h06;
      if (issGraph[k] !== 128'h2000 + k || issTag[k] !== expTag) bad++;
    end
    nTests++;
    if (sent != 40 || issGraph.size() != 40 || bad != 0) begin
      nFail++;
      $display("FAIL slow.stream: got sent=%0d issued=%0d badEntries=%0d expected 40/40/0",
               sent, issGraph.size(), bad);
    end
    nTests++;
    if (doneCyc < 0 || botsIssued !== 32'd40) begin
      nFail++;
      $display("FAIL slow.done: got doneCyc=%0d bots=%0d expected done/40", doneCyc, botsIssued);
    end
  endtask

  task automatic test_single();
    int sent, doneCyc;
    clearLogs();
    latency = 30;
    startJob(4'd9);
    sendJob(1, 128'hABC, 20, sent);
    @(negedge clk);
    nTests++;
    if (up.graphReady !== 1'b0 || isBotValid !== 1'b1 || extraDataOut !== 5'h19 || busy !== 1'b1) begin
      nFail++;
      $display("FAIL single.drain: got ready=%b valid=%b extra=%h busy=%b expected 0/1/19/1",
               up.graphReady, isBotValid, extraDataOut, busy);
    end
    waitDone(100, doneCyc);
    nTests++;
    if (doneCyc < 0 || inFlight !== 10'd0 || botsIssued !== 32'd1) begin
      nFail++;
      $display("FAIL single.done: got doneCyc=%0d inFlight=%0d bots=%0d expected done/0/1",
               doneCyc, inFlight, botsIssued);
    end
  endtask

  task automatic test_same_cycle();
    int sent, doneCyc, w;
    logic [9:0] preVal, postVal;
    bit found;
    clearLogs();
    latency = 7;
    found   = 1'b0;
    preVal  = '0;
    postVal = '0;
    startJob(4'd1);
    fork
      sendJob(12, 128'h500, 60, sent);
      begin
        w = 0;
        while (!found && w < 60) begin
          @(negedge clk); #1;
          if (isBotValid === 1'b1 && resultValid === 1'b1) begin
            found  = 1'b1;
            preVal = inFlight;
          end
          w++;
        end
        @(negedge clk); #1;
        postVal = inFlight;
      end
    join
    nTests++;
    if (!found || preVal !== 10'd7 || postVal !== 10'd7) begin
      nFail++;
      $display("FAIL same_cycle.inflight: got found=%0d before=%0d after=%0d expected 1/7/7",
               found, preVal, postVal);
    end
    waitDone(100, doneCyc);
    nTests++;
    if (doneCyc < 0 || inFlight !== 10'd0 || protocolError !== 1'b0) begin
      nFail++;
      $display("FAIL same_cycle.done: got doneCyc=%0d inFlight=%0d err=%b expected done/0/0",
               doneCyc, inFlight, protocolError);
    end
  endtask

  task automatic test_tag_error();
    int sent, doneCyc;
    clearLogs();
    latency = 40;
    startJob(4'd3);
    sendJob(4, 128'h700, 30, sent);
    nTests++;
    if (protocolError !== 1'b0) begin
      nFail++;
      $display("FAIL tag_err.clean_before: got err=%b expected 0", protocolError);
    end
    injectResult(5'h05);
    @(negedge clk);
    nTests++;
    if (protocolError !== 1'b1) begin
      nFail++;
      $display("FAIL tag_err.flag: got err=%b expected 1", protocolError);
    end
    waitDone(200, doneCyc);
    nTests++;
    if (doneCyc < 0 || protocolError !== 1'b1) begin
      nFail++;
      $display("FAIL tag_err.at_done: got doneCyc=%0d err=%b expected done/1", doneCyc, protocolError);
    end
    @(negedge clk);
    nTests++;
    if (protocolError !== 1'b1) begin
      nFail++;
      $display("FAIL tag_err.sticky: got err=%b expected 1", protocolError);
    end
  endtask

  task automatic test_reset_midjob();
    int sent, doneCyc;
    clearLogs();
    latency = 1000;
    startJob(4'd7);
    sendJob(200, 128'h9000, 400, sent);
    repeat (2) @(negedge clk);
    nTests++;
    if (inFlight !== 10'd200 || busy !== 1'b1 || up.graphReady !== 1'b0) begin
      nFail++;
      $display("FAIL rst_mid.setup: got inFlight=%0d busy=%b ready=%b expected 200/1/0",
               inFlight, busy, up.graphReady);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clearLogs();
    @(negedge clk);
    nTests++;
    if ({busy, up.graphReady, isBotValid, jobDone, protocolError} !== 5'b0 ||
        botsIssued !== 32'd0 || inFlight !== 10'd0 || graphOut !== 128'd0 ||
        extraDataOut !== 5'd0) begin
      nFail++;
      $display("FAIL rst_mid.outputs: got flags=%b bots=%0d inFlight=%0d graph=%h extra=%h expected 0",
               {busy, up.graphReady, isBotValid, jobDone, protocolError}, botsIssued, inFlight,
               graphOut, extraDataOut);
    end
    injectResult(5'h07);
    injectResult(5'h17);
    @(negedge clk);
    nTests++;
    if (protocolError !== 1'b0 || inFlight !== 10'd0) begin
      nFail++;
      $display("FAIL rst_mid.stray: got err=%b inFlight=%0d expected 0/0", protocolError, inFlight);
    end
    latency = 10;
    startJob(4'd2);
    sendJob(3, 128'h30, 30, sent);
    waitDone(100, doneCyc);
    nTests++;
    if (doneCyc < 0 || botsIssued !== 32'd3 || protocolError !== 1'b0 || inFlight !== 10'd0) begin
      nFail++;
      $display("FAIL rst_mid.new_job: got doneCyc=%0d bots=%0d err=%b inFlight=%0d expected done/3/0/0",
               doneCyc, botsIssued, protocolError, inFlight);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by time limit expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    startTag      = '0;
    slowDownInput = 1'b0;
    up.graphValid = 1'b0;
    up.graphIn    = '0;
    up.graphLast  = 1'b0;
    test_reset();
    test_back_to_back();
    test_slowdown();
    test_single();
    test_same_cycle();
    test_tag_error();
    test_reset_midjob();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
